// File: rtl/action_mem_ctrl.sv
// action_mem_ctrl: shares the single action_mem read port between match-stage lookups and
// control-plane reads, passes control-plane writes through, forwards same-cycle write data
// into reads, and buffers tagged lookup responses in order against downstream backpressure.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   lk_req_valid/ready/addr/tag      lookup request (from match stage)
//   lk_rsp_valid/ready/data/tag      lookup response (2-deep in-order buffer head)
//   cp_wr_valid/ready/addr/data      control-plane write (never stalls)
//   cp_rd_valid/ready/addr           control-plane read request / grant
//   cp_rd_done, cp_rd_data           read-complete pulse and last read result
//   mem_rd_en/addr, mem_rd_data      action_mem read port (1-cycle registered read)
//   mem_wr_en/addr/data              action_mem write port
module action_mem_ctrl #(
   parameter  int unsigned ENTRIES    = 16,
   parameter  int unsigned ACTION_W   = 64,
   parameter  int unsigned TAG_W      = 8,
   parameter  int unsigned STARVE_MAX = 4,
   localparam int unsigned AW         = $clog2(ENTRIES)
) (
   input  logic                clk,
   input  logic                rst_n,

   input  logic                lk_req_valid,
   output logic                lk_req_ready,
   input  logic [AW-1:0]       lk_req_addr,
   input  logic [TAG_W-1:0]    lk_req_tag,

   output logic                lk_rsp_valid,
   input  logic                lk_rsp_ready,
   output logic [ACTION_W-1:0] lk_rsp_data,
   output logic [TAG_W-1:0]    lk_rsp_tag,

   input  logic                cp_wr_valid,
   output logic                cp_wr_ready,
   input  logic [AW-1:0]       cp_wr_addr,
   input  logic [ACTION_W-1:0] cp_wr_data,

   input  logic                cp_rd_valid,
   output logic                cp_rd_ready,
   input  logic [AW-1:0]       cp_rd_addr,
   output logic                cp_rd_done,
   output logic [ACTION_W-1:0] cp_rd_data,

   output logic                mem_rd_en,
   output logic [AW-1:0]       mem_rd_addr,
   input  logic [ACTION_W-1:0] mem_rd_data,

   output logic                mem_wr_en,
   output logic [AW-1:0]       mem_wr_addr,
   output logic [ACTION_W-1:0] mem_wr_data
);

   localparam int unsigned SW  = $clog2(STARVE_MAX + 1);
   localparam int unsigned OCW = 3;

   // read pipeline stage between issue and data return
   typedef struct packed {
      logic                valid;
      logic                cp;
      logic [TAG_W-1:0]    tag;
      logic                byp;
      logic [ACTION_W-1:0] byp_data;
   } s1_t;

   s1_t                 s1_q;
   s1_t                 s1_d;

   logic [1:0]          fifo_cnt;
   logic                fifo_rd_ptr;
   logic                fifo_wr_ptr;
   logic [ACTION_W-1:0] fifo_data [2];
   logic [TAG_W-1:0]    fifo_tag  [2];

   logic [SW-1:0]       starve_cnt;
   logic [ACTION_W-1:0] cp_data_q;

   logic                s1_lk;
   logic                rsp_pop;
   logic [OCW-1:0]      occ;
   logic                credit;
   logic                cp_force;
   logic                lk_go;
   logic [ACTION_W-1:0] result;

   // write port passthrough
   always_comb begin
      cp_wr_ready = rst_n;
      mem_wr_en   = cp_wr_valid & rst_n;
      mem_wr_addr = cp_wr_addr;
      mem_wr_data = cp_wr_data;
   end

   // read arbitration: lookups win unless the cp read has been starved long enough
   always_comb begin
      s1_lk        = s1_q.valid & ~s1_q.cp;
      rsp_pop      = lk_rsp_valid & lk_rsp_ready;
      // buffered + in-flight lookups after this cycle's pop must leave a free slot
      occ          = OCW'(fifo_cnt) + OCW'(s1_lk) - OCW'(rsp_pop);
      credit       = (occ < OCW'(2));
      cp_force     = cp_rd_valid & (starve_cnt == SW'(STARVE_MAX));
      lk_req_ready = rst_n & credit & ~cp_force;
      lk_go        = lk_req_valid & lk_req_ready;
      cp_rd_ready  = rst_n & cp_rd_valid & (~lk_go | cp_force);
      mem_rd_en    = lk_go | cp_rd_ready;
      mem_rd_addr  = cp_rd_ready ? cp_rd_addr : lk_req_addr;
   end

   // issue-cycle capture, including write data to forward on an address hit
   always_comb begin
      s1_d          = '0;
      s1_d.valid    = mem_rd_en;
      s1_d.cp       = cp_rd_ready;
      s1_d.tag      = lk_req_tag;
      s1_d.byp      = cp_wr_valid & (cp_wr_addr == mem_rd_addr);
      s1_d.byp_data = cp_wr_data;
   end

   // data cycle result and response outputs
   always_comb begin
      result       = s1_q.byp ? s1_q.byp_data : mem_rd_data;
      lk_rsp_valid = (fifo_cnt != 2'd0);
      lk_rsp_data  = lk_rsp_valid ? fifo_data[fifo_rd_ptr] : '0;
      lk_rsp_tag   = lk_rsp_valid ? fifo_tag[fifo_rd_ptr]  : '0;
      cp_rd_done   = s1_q.valid & s1_q.cp;
      cp_rd_data   = cp_rd_done ? result : cp_data_q;
   end

   // pipeline stage register; reset drops any in-flight read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= '0;
      end else begin
         s1_q <= s1_d;
      end
   end

   // 2-entry in-order response buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_cnt     <= 2'd0;
         fifo_rd_ptr  <= 1'b0;
         fifo_wr_ptr  <= 1'b0;
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_tag[0]  <= '0;
         fifo_tag[1]  <= '0;
      end else begin
         if (s1_lk) begin
            fifo_data[fifo_wr_ptr] <= result;
            fifo_tag[fifo_wr_ptr]  <= s1_q.tag;
            fifo_wr_ptr            <= ~fifo_wr_ptr;
         end
         if (rsp_pop) begin
            fifo_rd_ptr <= ~fifo_rd_ptr;
         end
         unique case ({s1_lk, rsp_pop})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // consecutive cycles a waiting cp read lost the port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (cp_rd_valid && !cp_rd_ready) begin
         if (starve_cnt != SW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
         end
      end else begin
         starve_cnt <= '0;
      end
   end

   // hold last cp read result between completions
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cp_data_q <= '0;
      end else if (cp_rd_done) begin
         cp_data_q <= result;
      end
   end

endmodule

// File: tb/tb_action_mem_ctrl.sv
// Testbench for action_mem_ctrl: directed table, reset sequence and randomized traffic,
// all checked against a transaction-level model (outstanding-lookup queue with due cycles,
// shadow memory, pending cp read, starvation count).
module tb_action_mem_ctrl;

   localparam int unsigned AW   = 4;
   localparam int unsigned DW   = 64;
   localparam int unsigned TW   = 8;
   localparam int          SMAX = 4;

   logic          clk;
   logic          rst_n;
   logic          lk_req_valid, lk_req_ready;
   logic [AW-1:0] lk_req_addr;
   logic [TW-1:0] lk_req_tag;
   logic          lk_rsp_valid, lk_rsp_ready;
   logic [DW-1:0] lk_rsp_data;
   logic [TW-1:0] lk_rsp_tag;
   logic          cp_wr_valid, cp_wr_ready;
   logic [AW-1:0] cp_wr_addr;
   logic [DW-1:0] cp_wr_data;
   logic          cp_rd_valid, cp_rd_ready;
   logic [AW-1:0] cp_rd_addr;
   logic          cp_rd_done;
   logic [DW-1:0] cp_rd_data;
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data;
   logic          mem_wr_en;
   logic [AW-1:0] mem_wr_addr;
   logic [DW-1:0] mem_wr_data;

   action_mem_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .lk_req_valid(lk_req_valid), .lk_req_ready(lk_req_ready),
      .lk_req_addr(lk_req_addr), .lk_req_tag(lk_req_tag),
      .lk_rsp_valid(lk_rsp_valid), .lk_rsp_ready(lk_rsp_ready),
      .lk_rsp_data(lk_rsp_data), .lk_rsp_tag(lk_rsp_tag),
      .cp_wr_valid(cp_wr_valid), .cp_wr_ready(cp_wr_ready),
      .cp_wr_addr(cp_wr_addr), .cp_wr_data(cp_wr_data),
      .cp_rd_valid(cp_rd_valid), .cp_rd_ready(cp_rd_ready),
      .cp_rd_addr(cp_rd_addr), .cp_rd_done(cp_rd_done), .cp_rd_data(cp_rd_data),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // action memory: registered read returns the pre-write value on a same-edge collision
   logic [DW-1:0] amem [16];
   always @(posedge clk) begin
      if (mem_wr_en) amem[mem_wr_addr] <= mem_wr_data;
      if (mem_rd_en) mem_rd_data <= amem[mem_rd_addr];
   end

   typedef struct {
      logic          lkv;
      logic [AW-1:0] lka;
      logic [TW-1:0] lkt;
      logic          rdy;
      logic          wv;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic          cpv;
      logic [AW-1:0] cpa;
   } in_t;

   typedef struct {
      in_t           i;
      logic          e_lkr;
      logic          e_cpr;
      logic          e_rv;
      logic [TW-1:0] e_rt;
      logic          e_done;
      logic          dchk;
      logic [DW-1:0] e_rd;
   } vec_t;

   typedef struct {
      logic [DW-1:0] d;
      logic [TW-1:0] t;
      int            due;
   } rsp_t;

   int            checks = 0;
   int            errors = 0;

   // model state
   logic [DW-1:0] shadow [16];
   rsp_t          lq[$];
   int            cyc = 0;
   bit            cp_pend = 0;
   int            cp_due = 0;
   logic [DW-1:0] cp_exp = '0;
   logic [DW-1:0] cp_last = '0;
   int            starve = 0;
   bit            m_cp_go = 0;

   vec_t          vec[$];

   function automatic logic [DW-1:0] init_val(input int i);
      return 64'hC0DE_0000_0000_0100 + 64'(i);
   endfunction

   function automatic in_t mk_in(input int lkv, input int lka, input int lkt, input int rdy,
                                 input int wv, input int wa, input logic [DW-1:0] wd,
                                 input int cpv, input int cpa);
      in_t v;
      v.lkv = 1'(lkv); v.lka = AW'(lka); v.lkt = TW'(lkt); v.rdy = 1'(rdy);
      v.wv  = 1'(wv);  v.wa  = AW'(wa);  v.wd  = wd;
      v.cpv = 1'(cpv); v.cpa = AW'(cpa);
      return v;
   endfunction

   function automatic vec_t mk(input int lkv, input int lka, input int lkt, input int rdy,
                               input int wv, input int wa, input logic [DW-1:0] wd,
                               input int cpv, input int cpa,
                               input int e_lkr, input int e_cpr, input int e_rv,
                               input int e_rt, input int e_done);
      vec_t v;
      v.i      = mk_in(lkv, lka, lkt, rdy, wv, wa, wd, cpv, cpa);
      v.e_lkr  = 1'(e_lkr);
      v.e_cpr  = 1'(e_cpr);
      v.e_rv   = 1'(e_rv);
      v.e_rt   = TW'(e_rt);
      v.e_done = 1'(e_done);
      v.dchk   = 1'b0;
      v.e_rd   = '0;
      return v;
   endfunction

   function automatic vec_t idle(input int e_rv, input int e_rt);
      return mk(0, 0, 0, 1, 0, 0, 64'h0, 0, 0, 1, 0, e_rv, e_rt, 0);
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic drive(input in_t v);
      lk_req_valid = v.lkv; lk_req_addr = v.lka; lk_req_tag = v.lkt;
      lk_rsp_ready = v.rdy;
      cp_wr_valid  = v.wv;  cp_wr_addr  = v.wa;  cp_wr_data = v.wd;
      cp_rd_valid  = v.cpv; cp_rd_addr  = v.cpa;
   endtask

   // one cycle of the transaction model: predict, compare, then advance
   task automatic model_check(input in_t v);
      bit            exp_rv, pop, credit, force_c, lk_go, cp_go, done;
      logic [DW-1:0] val;
      exp_rv  = (lq.size() > 0) && (lq[0].due <= cyc);
      pop     = exp_rv && v.rdy;
      credit  = (lq.size() - int'(pop)) < 2;
      force_c = v.cpv && (starve == SMAX);
      lk_go   = v.lkv && credit && !force_c;
      cp_go   = v.cpv && (!lk_go || force_c);
      chk("lk_req_ready", 64'(lk_req_ready), 64'(credit && !force_c));
      chk("cp_rd_ready",  64'(cp_rd_ready),  64'(cp_go));
      chk("mem_wr_en",    64'(mem_wr_en),    64'(v.wv));
      chk("lk_rsp_valid", 64'(lk_rsp_valid), 64'(exp_rv));
      if (exp_rv) begin
         chk("lk_rsp_data", lk_rsp_data, lq[0].d);
         chk("lk_rsp_tag",  64'(lk_rsp_tag), 64'(lq[0].t));
      end else begin
         chk("lk_rsp_data_idle", lk_rsp_data, 64'h0);
         chk("lk_rsp_tag_idle",  64'(lk_rsp_tag), 64'h0);
      end
      done = cp_pend && (cp_due == cyc);
      chk("cp_rd_done", 64'(cp_rd_done), 64'(done));
      if (done) begin
         cp_last = cp_exp;
         cp_pend = 0;
      end
      chk("cp_rd_data", cp_rd_data, cp_last);
      if (pop) void'(lq.pop_front());
      if (lk_go) begin
         val = (v.wv && v.wa == v.lka) ? v.wd : shadow[v.lka];
         lq.push_back('{d: val, t: v.lkt, due: cyc + 2});
      end
      if (cp_go) begin
         cp_pend = 1;
         cp_due  = cyc + 1;
         cp_exp  = (v.wv && v.wa == v.cpa) ? v.wd : shadow[v.cpa];
      end
      if (v.cpv && !cp_go) starve = (starve < SMAX) ? starve + 1 : SMAX;
      else                 starve = 0;
      if (v.wv) shadow[v.wa] = v.wd;
      m_cp_go = cp_go;
      cyc++;
   endtask

   task automatic tick(input in_t v);
      @(negedge clk);
      drive(v);
      #2;
      model_check(v);
   endtask

   task automatic model_reset();
      lq.delete();
      cp_pend = 0;
      cp_last = '0;
      starve  = 0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " lk_req_ready"}, 64'(lk_req_ready), 64'h0);
      chk({tag, " cp_rd_ready"},  64'(cp_rd_ready),  64'h0);
      chk({tag, " cp_wr_ready"},  64'(cp_wr_ready),  64'h0);
      chk({tag, " mem_rd_en"},    64'(mem_rd_en),    64'h0);
      chk({tag, " mem_wr_en"},    64'(mem_wr_en),    64'h0);
      chk({tag, " lk_rsp_valid"}, 64'(lk_rsp_valid), 64'h0);
      chk({tag, " lk_rsp_data"},  lk_rsp_data,       64'h0);
      chk({tag, " lk_rsp_tag"},   64'(lk_rsp_tag),   64'h0);
      chk({tag, " cp_rd_done"},   64'(cp_rd_done),   64'h0);
      chk({tag, " cp_rd_data"},   cp_rd_data,        64'h0);
   endtask

   // hold reset across two edges with busy inputs, then release at a negedge
   task automatic do_reset(input string tag);
      in_t busy;
      busy = mk_in(1, 2, 8'h77, 1, 1, 2, 64'h1234, 1, 2);
      @(negedge clk);
      drive(busy);
      rst_n = 1'b0;
      #2;
      check_all_zero({tag, " a"});
      model_reset();
      @(negedge clk);
      #2;
      check_all_zero({tag, " b"});
      @(negedge clk);
      rst_n = 1'b1;
      drive(mk_in(0, 0, 0, 1, 0, 0, 64'h0, 0, 0));
      #2;
      model_check(mk_in(0, 0, 0, 1, 0, 0, 64'h0, 0, 0));
   endtask

   initial begin
      vec_t v;
      in_t  ri;
      bit   cp_hold;
      logic [AW-1:0] cpa_r;

      for (int i = 0; i < 16; i++) begin
         amem[i]   = init_val(i);
         shadow[i] = init_val(i);
      end
      rst_n = 1'b0;
      drive(mk_in(0, 0, 0, 1, 0, 0, 64'h0, 0, 0));
      do_reset("rst0");

      // write addr3, lookup it two cycles later
      vec.push_back(mk(0, 0, 0, 1, 1, 3, 64'hDEAD_BEEF_0000_0001, 0, 0, 1, 0, 0, 0, 0));
      vec.push_back(idle(0, 0));
      vec.push_back(mk(1, 3, 8'h11, 1, 0, 0, 64'h0, 0, 0, 1, 0, 0, 0, 0));
      vec.push_back(idle(0, 0));
      v = idle(1, 8'h11); v.dchk = 1; v.e_rd = 64'hDEAD_BEEF_0000_0001; vec.push_back(v);
      // same-cycle write and lookup of addr5 must bypass
      vec.push_back(mk(1, 5, 8'h22, 1, 1, 5, 64'hA5A5, 0, 0, 1, 0, 0, 0, 0));
      vec.push_back(idle(0, 0));
      v = idle(1, 8'h22); v.dchk = 1; v.e_rd = 64'hA5A5; vec.push_back(v);
      // 8 back-to-back lookups
      for (int i = 0; i < 8; i++)
         vec.push_back(mk(1, i, i, 1, 0, 0, 64'h0, 0, 0, 1, 0, int'(i >= 2), i - 2, 0));
      vec.push_back(idle(1, 6));
      vec.push_back(idle(1, 7));
      vec.push_back(idle(0, 0));
      // backpressure: two accepted, then stall until rsp_ready returns
      vec.push_back(mk(1, 1, 8'h30, 0, 0, 0, 64'h0, 0, 0, 1, 0, 0, 0, 0));
      vec.push_back(mk(1, 2, 8'h31, 0, 0, 0, 64'h0, 0, 0, 1, 0, 0, 0, 0));
      vec.push_back(mk(1, 3, 8'h32, 0, 0, 0, 64'h0, 0, 0, 0, 0, 1, 8'h30, 0));
      vec.push_back(mk(1, 3, 8'h32, 0, 0, 0, 64'h0, 0, 0, 0, 0, 1, 8'h30, 0));
      vec.push_back(mk(1, 3, 8'h32, 1, 0, 0, 64'h0, 0, 0, 1, 0, 1, 8'h30, 0));
      vec.push_back(idle(1, 8'h31));
      vec.push_back(idle(1, 8'h32));
      vec.push_back(idle(0, 0));
      // cp read of addr7 starved by lookups, forced on its 5th waiting cycle
      for (int k = 0; k < 4; k++)
         vec.push_back(mk(1, k, 8'h40 + k, 1, 0, 0, 64'h0, 1, 7, 1, 0,
                          int'(k >= 2), 8'h40 + k - 2, 0));
      vec.push_back(mk(1, 4, 8'h44, 1, 0, 0, 64'h0, 1, 7, 0, 1, 1, 8'h42, 0));
      vec.push_back(mk(1, 4, 8'h44, 1, 0, 0, 64'h0, 0, 0, 1, 0, 1, 8'h43, 1));
      vec.push_back(idle(0, 0));
      vec.push_back(idle(1, 8'h44));
      vec.push_back(idle(0, 0));

      for (int r = 0; r < vec.size(); r++) begin
         tick(vec[r].i);
         chk($sformatf("row%0d lk_req_ready", r), 64'(lk_req_ready), 64'(vec[r].e_lkr));
         chk($sformatf("row%0d cp_rd_ready", r),  64'(cp_rd_ready),  64'(vec[r].e_cpr));
         chk($sformatf("row%0d lk_rsp_valid", r), 64'(lk_rsp_valid), 64'(vec[r].e_rv));
         if (vec[r].e_rv)
            chk($sformatf("row%0d lk_rsp_tag", r), 64'(lk_rsp_tag), 64'(vec[r].e_rt));
         chk($sformatf("row%0d cp_rd_done", r), 64'(cp_rd_done), 64'(vec[r].e_done));
         if (vec[r].dchk)
            chk($sformatf("row%0d lk_rsp_data", r), lk_rsp_data, vec[r].e_rd);
      end
      chk("starved cp_rd_data held", cp_rd_data, init_val(7));

      // reset with two lookups in flight: nothing may emerge afterwards
      tick(mk_in(1, 1, 8'h50, 1, 0, 0, 64'h0, 0, 0));
      tick(mk_in(1, 2, 8'h51, 1, 0, 0, 64'h0, 0, 0));
      do_reset("rst1");
      for (int i = 0; i < 4; i++) begin
         tick(mk_in(0, 0, 0, 1, 0, 0, 64'h0, 0, 0));
         chk("post-reset lk_rsp_valid", 64'(lk_rsp_valid), 64'h0);
      end
      tick(mk_in(1, 9, 8'h60, 1, 0, 0, 64'h0, 0, 0));
      repeat (3) tick(mk_in(0, 0, 0, 1, 0, 0, 64'h0, 0, 0));

      // randomized traffic; a cp read request is held until granted
      cp_hold = 0;
      cpa_r   = '0;
      for (int n = 0; n < 3000; n++) begin
         if (!cp_hold) begin
            cp_hold = ($urandom_range(0, 5) == 0);
            cpa_r   = AW'($urandom_range(0, 15));
         end
         ri.lkv = ($urandom_range(0, 3) != 0);
         ri.lka = AW'($urandom_range(0, 15));
         ri.lkt = TW'($urandom);
         ri.rdy = ($urandom_range(0, 9) < 7);
         ri.wv  = ($urandom_range(0, 2) == 0);
         ri.wa  = ($urandom_range(0, 1) == 0) ? ri.lka
                : (($urandom_range(0, 1) == 0) ? cpa_r : AW'($urandom_range(0, 15)));
         ri.wd  = {$urandom, $urandom};
         ri.cpv = cp_hold;
         ri.cpa = cpa_r;
         tick(ri);
         if (m_cp_go) cp_hold = 0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
